fir_stream_param: RTL and testbench
===================================

FIR_STREAM_PARAM -- requirements
Module: fir_stream_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of samples, taps, accumulator and Wishbone data.
REQ-002 SHALL have parameter MAX_TAPS, default 16: number of tap and sample registers, 1..32.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have Wishbone slave ports, all inputs except where marked:
- wbs_cyc_i 1, wbs_stb_i 1, wbs_we_i 1
- wbs_sel_i 4 (ignored; full-word access only)
- wbs_adr_i 32, wbs_dat_i DATA_W
- wbs_ack_o output 1, wbs_dat_o output DATA_W
REQ-006 SHALL have AXI-Stream slave ports: ss_tvalid in 1, ss_tready out 1, ss_tdata in DATA_W, ss_tlast in 1.
REQ-007 SHALL have AXI-Stream master ports: sm_tvalid out 1, sm_tready in 1, sm_tdata out DATA_W, sm_tlast out 1.

Function
REQ-008 SHALL decode this register map:
- 0x00 AP_CTRL: bit0 ap_start (W1 starts), bit1 ap_done (RO, sticky), bit2 ap_idle (RO)
- 0x10 DATA_LEN: number of samples per run, 32 bit
- 0x14 TAP_NUM: active taps, legal 1..MAX_TAPS
- 0x40 + 4k: tap k, k < MAX_TAPS
REQ-009 SHALL pulse wbs_ack_o for exactly one cycle, on the cycle after cyc&stb is first sampled high; no further ack until cyc&stb deasserts.
REQ-010 Reads of unmapped addresses SHALL return 0 and still ack.
REQ-011 Writes to DATA_LEN, TAP_NUM and taps SHALL be ignored while not idle; the access still acks.
REQ-012 TAP_NUM writes SHALL saturate: values 0 store as 1; values > MAX_TAPS store as MAX_TAPS.
REQ-013 Reading AP_CTRL SHALL clear ap_done on the cycle of the ack.
REQ-014 FSM states and transitions:
- IDLE -> WAIT_IN: on ap_start write with DATA_LEN != 0
- WAIT_IN -> MAC: on ss handshake
- MAC -> OUT: after TAP_NUM cycles
- OUT -> WAIT_IN: on sm handshake, if the run is not finished
- OUT -> IDLE: on the final sm handshake
REQ-015 ap_start with DATA_LEN = 0 SHALL set ap_done immediately and stay IDLE.
REQ-016 ap_start SHALL clear all sample registers and the output count to zero.
REQ-017 ss_tready SHALL equal (state == WAIT_IN); on handshake the sample shifts into x[0], older samples move down, and x[MAX_TAPS-1] is dropped.
REQ-018 MAC SHALL run one multiply-accumulate per cycle: acc += tap[i]*x[i] for i = 0..TAP_NUM-1, signed, product and sum truncated to DATA_W (two's-complement wrap).
REQ-019 sm_tvalid SHALL rise exactly TAP_NUM+1 cycles after the ss handshake edge.
REQ-020 sm_tdata, sm_tvalid and sm_tlast SHALL be registered and held stable until sm_tready.
REQ-021 sm_tlast SHALL be 1 on output number DATA_LEN (1-based); ss_tlast SHALL be ignored for termination.
REQ-022 Final sm handshake SHALL set ap_done and ap_idle in the following cycle.
REQ-023 ap_start written while not idle SHALL be ignored.
REQ-024 Sample history SHALL persist across all outputs within one run; early outputs use zeros for unfilled history.

Reset
REQ-025 While rst_n = 0, all of the following SHALL hold regardless of clk:
- state = IDLE, ap_idle = 1, ap_done = 0
- taps, samples, DATA_LEN, accumulator and counters = 0; TAP_NUM = 1
- outputs: wbs_ack_o = 0, wbs_dat_o = 0, ss_tready = 0, sm_tvalid = 0, sm_tdata = 0, sm_tlast = 0
REQ-026 Reset asserted mid-run SHALL abort the run with no output emitted; after release the block SHALL accept a fresh configuration.

Verification
REQ-027 Basic run: TAP_NUM = 11, taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, DATA_LEN = 100, random signed data in range ±299 -> all outputs match golden convolution; sm_tlast = 1 only on output 100; ap_done = 1 afterwards.
REQ-028 Latency: TAP_NUM = 5, one sample 7, tap0 = 3 -> sm_tvalid rises 6 cycles after the ss handshake; sm_tdata = 21.
REQ-029 Backpressure: sm_tready held low for 20 cycles -> sm_tdata stable and ss_tready = 0 throughout; no sample lost.
REQ-030 Busy write: write tap0 = 99 mid-run -> access acks; outputs unchanged; reading tap0 back after done returns the old value.
REQ-031 Edge config: TAP_NUM write 0 reads back 1; TAP_NUM write 40 reads back MAX_TAPS; ap_start with DATA_LEN = 0 -> ap_done = 1, ss_tready stays 0.
REQ-032 Reset mid-run: rst_n low during MAC -> sm_tvalid = 0 and ap_idle = 1 immediately; a second full run then passes golden.

Source files
------------

// File: rtl/fir_stream_param.sv
// fir_stream_param: streaming FIR filter with a Wishbone control/tap register
// file, an AXI-Stream sample input and an AXI-Stream result output.
//
// Ports
//   clk, rst_n           : single rising-edge clock, asynchronous active-low reset
//   wbs_*                : Wishbone slave (single-cycle registered ack, full-word access)
//   ss_tvalid/ss_tready/ss_tdata/ss_tlast : sample input stream (ss_tlast unused)
//   sm_tvalid/sm_tready/sm_tdata/sm_tlast : filtered output stream
//
// Register map (byte addresses)
//   0x00 AP_CTRL  : bit0 ap_start (write 1), bit1 ap_done (sticky, clear on read), bit2 ap_idle
//   0x10 DATA_LEN : samples per run
//   0x14 TAP_NUM  : active taps, saturated to 1..MAX_TAPS
//   0x40 + 4k     : tap k
module fir_stream_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_TAPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // Wishbone slave
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    // sample input stream
    input  logic              ss_tvalid,
    output logic              ss_tready,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    // result output stream
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast
);

    localparam int unsigned TN_W  = $clog2(MAX_TAPS + 1);
    localparam int unsigned IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

    localparam logic [31:0] ADR_CTRL    = 32'h0000_0000;
    localparam logic [31:0] ADR_LEN     = 32'h0000_0010;
    localparam logic [31:0] ADR_TAPN    = 32'h0000_0014;
    localparam logic [31:0] ADR_TAP0    = 32'h0000_0040;
    localparam logic [31:0] ADR_TAP_END = 32'(64 + 4 * MAX_TAPS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_MAC     = 2'd2,
        S_OUT     = 2'd3
    } state_e;

    state_e              state_q;
    logic                idle_q;
    logic                done_q;
    logic [31:0]         data_len_q;
    logic [TN_W-1:0]     tap_num_q;
    logic [DATA_W-1:0]   taps_q [MAX_TAPS];
    logic [DATA_W-1:0]   x_q    [MAX_TAPS];
    logic [DATA_W-1:0]   acc_q;
    logic [IDX_W-1:0]    mac_idx_q;
    logic [31:0]         out_cnt_q;
    logic                ack_q;
    logic                acked_q;
    logic [DATA_W-1:0]   rd_dat_q;
    logic                ss_tready_q;
    logic                sm_tvalid_q;
    logic [DATA_W-1:0]   sm_tdata_q;
    logic                sm_tlast_q;

    logic                bus_req_c;
    logic                is_tap_c;
    logic [IDX_W-1:0]    tap_idx_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic                mac_last_c;
    logic                unused_c;

    assign unused_c = ^{wbs_sel_i, ss_tlast};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rd_dat_q;
    assign ss_tready = ss_tready_q;
    assign sm_tvalid = sm_tvalid_q;
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;

    // Address decode and read mux
    always_comb begin
        bus_req_c  = wbs_cyc_i & wbs_stb_i;
        is_tap_c   = (wbs_adr_i >= ADR_TAP0) && (wbs_adr_i < ADR_TAP_END) &&
                     (wbs_adr_i[1:0] == 2'b00);
        // tap k sits at word 16 + k; subtracting 16 yields k for in-range addresses
        tap_idx_c  = wbs_adr_i[IDX_W+1:2] - IDX_W'(16);
        mac_last_c = (TN_W'(mac_idx_q) == (tap_num_q - TN_W'(1)));
        rd_data_c  = '0;
        if (wbs_adr_i == ADR_CTRL) begin
            rd_data_c = DATA_W'({idle_q, done_q, 1'b0});
        end else if (wbs_adr_i == ADR_LEN) begin
            rd_data_c = DATA_W'(data_len_q);
        end else if (wbs_adr_i == ADR_TAPN) begin
            rd_data_c = DATA_W'(tap_num_q);
        end else if (is_tap_c) begin
            rd_data_c = taps_q[tap_idx_c];
        end
    end

    // Bus register file, control FSM and MAC datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idle_q      <= 1'b1;
            done_q      <= 1'b0;
            data_len_q  <= '0;
            tap_num_q   <= TN_W'(1);
            for (int i = 0; i < int'(MAX_TAPS); i++) begin
                taps_q[i] <= '0;
                x_q[i]    <= '0;
            end
            acc_q       <= '0;
            mac_idx_q   <= '0;
            out_cnt_q   <= '0;
            ack_q       <= 1'b0;
            acked_q     <= 1'b0;
            rd_dat_q    <= '0;
            ss_tready_q <= 1'b0;
            sm_tvalid_q <= 1'b0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
        end else begin
            // One ack per cyc&stb assertion; re-armed once the request drops
            ack_q <= 1'b0;
            if (!bus_req_c) begin
                acked_q <= 1'b0;
            end
            if (bus_req_c && !acked_q) begin
                ack_q   <= 1'b1;
                acked_q <= 1'b1;
                if (wbs_we_i) begin
                    if (wbs_adr_i == ADR_CTRL) begin
                        if (wbs_dat_i[0] && (state_q == S_IDLE)) begin
                            for (int i = 0; i < int'(MAX_TAPS); i++) begin
                                x_q[i] <= '0;
                            end
                            out_cnt_q <= '0;
                            if (data_len_q == 32'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= S_WAIT_IN;
                                idle_q      <= 1'b0;
                                ss_tready_q <= 1'b1;
                            end
                        end
                    end else if (state_q == S_IDLE) begin
                        if (wbs_adr_i == ADR_LEN) begin
                            data_len_q <= 32'(wbs_dat_i);
                        end else if (wbs_adr_i == ADR_TAPN) begin
                            if (wbs_dat_i == '0) begin
                                tap_num_q <= TN_W'(1);
                            end else if (wbs_dat_i > DATA_W'(MAX_TAPS)) begin
                                tap_num_q <= TN_W'(MAX_TAPS);
                            end else begin
                                tap_num_q <= TN_W'(wbs_dat_i);
                            end
                        end else if (is_tap_c) begin
                            taps_q[tap_idx_c] <= wbs_dat_i;
                        end
                    end
                end else begin
                    rd_dat_q <= rd_data_c;
                    if (wbs_adr_i == ADR_CTRL) begin
                        done_q <= 1'b0;
                    end
                end
            end

            case (state_q)
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        for (int i = int'(MAX_TAPS) - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]      <= ss_tdata;
                        acc_q       <= '0;
                        mac_idx_q   <= '0;
                        ss_tready_q <= 1'b0;
                        state_q     <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Low DATA_W bits of the product are sign-independent, so plain wrap is exact
                    acc_q     <= acc_q + taps_q[mac_idx_q] * x_q[mac_idx_q];
                    mac_idx_q <= mac_idx_q + IDX_W'(1);
                    if (mac_last_c) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    // First OUT cycle registers the result; later cycles wait for the sink
                    if (!sm_tvalid_q) begin
                        sm_tvalid_q <= 1'b1;
                        sm_tdata_q  <= acc_q;
                        sm_tlast_q  <= ((out_cnt_q + 32'd1) == data_len_q);
                    end else if (sm_tready) begin
                        sm_tvalid_q <= 1'b0;
                        sm_tlast_q  <= 1'b0;
                        out_cnt_q   <= out_cnt_q + 32'd1;
                        if (sm_tlast_q) begin
                            state_q <= S_IDLE;
                            idle_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_WAIT_IN;
                            ss_tready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_param.sv
// tb_fir_stream_param: directed sequence with randomized sample data for
// fir_stream_param, checked against a direct convolution model.
module tb_fir_stream_param;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_TAPS = 16;

    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_LEN  = 32'h10;
    localparam logic [31:0] A_TAPN = 32'h14;
    localparam logic [31:0] A_TAP0 = 32'h40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic              ss_tvalid, ss_tready, ss_tlast;
    logic [DATA_W-1:0] ss_tdata;
    logic              sm_tvalid, sm_tready, sm_tlast;
    logic [DATA_W-1:0] sm_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    int taps_m [MAX_TAPS];
    int tn_m;
    int xs [$];
    int base_taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    fir_stream_param #(.DATA_W(DATA_W), .MAX_TAPS(MAX_TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .sm_tvalid (sm_tvalid),
        .sm_tready (sm_tready),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n = 0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        do begin
            tick();
            n++;
        end while (!wbs_ack_o && n < 20);
        check("wb_ack", wbs_ack_o, 1'b1);
        rdat      = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, d, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        wb_xfer(1'b0, adr, 32'h0, d);
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check(tag, d, exp);
    endtask

    task automatic program_taps(input int tn);
        tn_m = tn;
        wb_write(A_TAPN, tn);
        for (int i = 0; i < int'(MAX_TAPS); i++) begin
            wb_write(A_TAP0 + 32'(4 * i), taps_m[i]);
        end
    endtask

    // Waits for ss_tready, then completes exactly one input handshake
    task automatic send_sample(input int s);
        int n = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = s;
        ss_tlast  = 1'($urandom_range(1));
        while (!ss_tready && n < 100) begin
            tick();
            n++;
        end
        check("ss_tready_wait", ss_tready, 1'b1);
        tick();
        ss_tvalid = 1'b0;
    endtask

    // Golden output n: y[n] = sum_k h[k] * x[n-k], zero history before the run
    function automatic int golden(input int n);
        int y = 0;
        for (int k = 0; k < tn_m; k++) begin
            if (n - k >= 0) y += taps_m[k] * xs[n - k];
        end
        return y;
    endfunction

    task automatic do_run(input int n, input int max_bp, input int bp20_at,
                          input int busy_at, input bit full_range);
        int          lat;
        int          bp;
        int          s;
        logic [31:0] hold;
        xs.delete();
        wb_write(A_LEN, n);
        wb_write(A_CTRL, 1);
        for (int k = 0; k < n; k++) begin
            if (full_range) s = int'($urandom);
            else            s = int'($urandom_range(598)) - 299;
            xs.push_back(s);
            if (k == busy_at) begin
                wb_write(A_TAP0, 99);
                wb_write(A_TAPN, 3);
                wb_write(A_LEN, 7);
                wb_write(A_CTRL, 1);
            end
            send_sample(s);
            lat = 0;
            while (!sm_tvalid && lat < 100) begin
                tick();
                lat++;
            end
            check("latency", lat, tn_m + 1);
            bp   = (k == bp20_at) ? 20 : int'($urandom_range(max_bp));
            hold = sm_tdata;
            for (int c = 0; c < bp; c++) begin
                tick();
                check("bp_tdata_hold", sm_tdata, hold);
                check("bp_tvalid_hold", sm_tvalid, 1'b1);
                check("bp_ss_tready", ss_tready, 1'b0);
            end
            check("sm_tdata", sm_tdata, golden(k));
            check("sm_tlast", sm_tlast, (k == n - 1));
            sm_tready = 1'b1;
            tick();
            sm_tready = 1'b0;
            check("sm_tvalid_drop", sm_tvalid, 1'b0);
        end
    endtask

    initial begin
        int          acks;
        logic [31:0] d;
        rst_n     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        ss_tvalid = 1'b0;
        ss_tdata  = '0;
        ss_tlast  = 1'b0;
        sm_tready = 1'b0;
        tn_m      = 1;

        // Reset state
        repeat (3) tick();
        check("rst_ack", wbs_ack_o, 1'b0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_ss_tready", ss_tready, 1'b0);
        check("rst_sm_tvalid", sm_tvalid, 1'b0);
        check("rst_sm_tdata", sm_tdata, 32'h0);
        check("rst_sm_tlast", sm_tlast, 1'b0);
        rst_n = 1'b1;
        tick();
        read_check("rst_ctrl", A_CTRL, 32'h4);
        read_check("rst_tapnum", A_TAPN, 32'd1);
        read_check("rst_len", A_LEN, 32'd0);
        read_check("rst_tap0", A_TAP0, 32'd0);

        // Ack is a single pulse even if cyc&stb is held
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = A_TAPN;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (wbs_ack_o) acks++;
        end
        check("ack_single_pulse", acks, 1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        tick();

        // Edge configuration
        wb_write(A_TAPN, 0);
        read_check("tapnum_sat_low", A_TAPN, 32'd1);
        wb_write(A_TAPN, 40);
        read_check("tapnum_sat_high", A_TAPN, MAX_TAPS);
        wb_write(A_TAPN, 7);
        read_check("tapnum_plain", A_TAPN, 32'd7);
        read_check("unmapped_20", 32'h20, 32'h0);
        read_check("unmapped_past_taps", 32'(64 + 4 * MAX_TAPS), 32'h0);
        wb_write(A_LEN, 0);
        wb_write(A_CTRL, 1);
        for (int c = 0; c < 3; c++) begin
            check("len0_ss_tready", ss_tready, 1'b0);
            tick();
        end
        read_check("len0_done", A_CTRL, 32'h6);
        read_check("done_cleared_by_read", A_CTRL, 32'h4);

        // Latency: single sample, tap0 = 3, five taps
        for (int i = 0; i < int'(MAX_TAPS); i++) taps_m[i] = int'($urandom_range(1000)) - 500;
        taps_m[0] = 3;
        program_taps(5);
        wb_write(A_LEN, 1);
        wb_write(A_CTRL, 1);
        xs.delete();
        xs.push_back(7);
        send_sample(7);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("lat_valid_low", sm_tvalid, 1'b0);
        end
        tick();
        check("lat_valid_rise", sm_tvalid, 1'b1);
        check("lat_tdata", sm_tdata, 32'd21);
        check("lat_tlast", sm_tlast, 1'b1);
        sm_tready = 1'b1;
        tick();
        sm_tready = 1'b0;
        read_check("lat_done", A_CTRL, 32'h6);

        // Basic run with backpressure and busy writes
        for (int i = 0; i < int'(MAX_TAPS); i++) taps_m[i] = int'($urandom_range(200)) - 100;
        for (int i = 0; i < 11; i++) taps_m[i] = base_taps[i];
        program_taps(11);
        do_run(100, 2, 10, 50, 1'b0);
        read_check("basic_done", A_CTRL, 32'h6);
        read_check("busy_tap0_kept", A_TAP0, taps_m[0]);
        read_check("busy_tapnum_kept", A_TAPN, 32'd11);
        read_check("busy_len_kept", A_LEN, 32'd100);

        // Reset during MAC
        for (int i = 0; i < int'(MAX_TAPS); i++) taps_m[i] = int'($urandom_range(200)) - 100;
        program_taps(8);
        wb_write(A_LEN, 5);
        wb_write(A_CTRL, 1);
        send_sample(123);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_sm_tvalid", sm_tvalid, 1'b0);
        check("midrst_ss_tready", ss_tready, 1'b0);
        check("midrst_sm_tdata", sm_tdata, 32'h0);
        repeat (12) begin
            tick();
            check("midrst_no_output", sm_tvalid, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_no_output", sm_tvalid, 1'b0);
        read_check("post_rst_ctrl", A_CTRL, 32'h4);
        read_check("post_rst_tapnum", A_TAPN, 32'd1);
        read_check("post_rst_tap0", A_TAP0, 32'd0);

        // Fresh full-range run after reset
        for (int i = 0; i < int'(MAX_TAPS); i++) taps_m[i] = int'($urandom);
        program_taps(MAX_TAPS);
        do_run(20, 3, -1, -1, 1'b1);
        read_check("second_done", A_CTRL, 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
